// File: rtl/rot_seq_pkg.sv
// rot_seq_pkg: shared types and constants for the rotation sequencer
package rot_seq_pkg;
    localparam int DATA_W = 4;
    localparam int AMT_W = 2;
    localparam logic DIR_LEFT = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;
    typedef enum logic [1:0] {IDLE, ROT, HOLD} state_t;
endpackage

// File: rtl/cyclic_rotator4.sv
// cyclic_rotator4: single-step 4-bit rotator (one position per use)
// Ports: en (1 = rotate, 0 = pass through), rot_dir (1 = left, 0 = right),
//        in_data (word in), out_data (word rotated by one position).
module cyclic_rotator4
    import rot_seq_pkg::*;
(
    input  logic              en,
    input  logic              rot_dir,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] out_data
);
    always_comb
        out_data = !en ? in_data :
                   (rot_dir == DIR_LEFT) ? {in_data[2:0], in_data[3]} : {in_data[0], in_data[3:1]};
endmodule

// File: rtl/rotate_sequencer4.sv
// rotate_sequencer4: multi-cycle rotation sequencer driving cyclic_rotator4 one step per clock
// Ports: clk/rst (sync active-high); in_valid/in_ready/in_data/in_amt/in_dir request port;
//        out_valid/out_ready/out_data result port; busy; done_cnt (wrapping STAT_W counter).
// Build option: ROT_SEQ_SHORTPATH_EN executes amount 3 as one step the other way.
module rotate_sequencer4
    import rot_seq_pkg::*;
#(
    parameter int STAT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [AMT_W-1:0]  in_amt,
    input  logic              in_dir,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic [STAT_W-1:0] done_cnt
);
    state_t             state_q, state_d;
    logic [DATA_W-1:0]  data_q, data_d, rot_out;
    logic               dir_q, dir_d, dir_eff;
    logic [AMT_W-1:0]   rem_q, rem_d, n_eff;
    logic [STAT_W-1:0]  cnt_q, cnt_d;

    cyclic_rotator4 u_rot (
        .en       (state_q == ROT),
        .rot_dir  (dir_q),
        .in_data  (data_q),
        .out_data (rot_out)
    );

`ifdef ROT_SEQ_SHORTPATH_EN
    // Rotating 3 one way equals rotating 1 the other way.
    always_comb begin
        n_eff   = (in_amt == 2'd3) ? 2'd1 : in_amt;
        dir_eff = (in_amt == 2'd3) ? ~in_dir : in_dir;
    end
`else
    always_comb begin
        n_eff   = in_amt;
        dir_eff = in_dir;
    end
`endif

    always_comb begin
        in_ready  = (state_q == IDLE) && !rst;
        out_valid = (state_q == HOLD);
        busy      = (state_q != IDLE);
        out_data  = data_q;
        done_cnt  = cnt_q;
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        dir_d   = dir_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: if (in_valid && in_ready) begin
                data_d  = in_data;
                dir_d   = dir_eff;
                rem_d   = n_eff;
                state_d = (n_eff == '0) ? HOLD : ROT;
            end
            ROT: begin
                data_d  = rot_out;
                rem_d   = rem_q - 1'b1;
                state_d = (rem_q == 2'd1) ? HOLD : ROT;
            end
            HOLD: if (out_ready) begin
                state_d = IDLE;
                cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            dir_q   <= 1'b0;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            dir_q   <= dir_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_rotate_sequencer4.sv
// tb_rotate_sequencer4: directed self-checking bench for rotate_sequencer4 (STAT_W = 2)
module tb_rotate_sequencer4;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = 4'd0;
    logic [1:0] in_amt = 2'd0;
    logic       in_dir = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_data;
    logic       busy;
    logic [1:0] done_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [1:0] exp_cnt = 2'd0;

`ifdef ROT_SEQ_SHORTPATH_EN
    localparam int N_AMT3 = 1;
`else
    localparam int N_AMT3 = 3;
`endif

    rotate_sequencer4 #(.STAT_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_dir    (in_dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, scramble the inputs after acceptance, count cycles to out_valid.
    task automatic do_op(input logic [3:0] d, input logic [1:0] a, input logic dir,
                         input logic [3:0] exp_d, input int exp_n, input string nm);
        int cyc;
        in_valid = 1'b1; in_data = d; in_amt = a; in_dir = dir;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL %s ready_before: got %b want 1", nm, in_ready); end
        step();
        in_valid = 1'b0; in_data = ~d; in_amt = ~a; in_dir = ~dir;
        cyc = 0;
        while (!out_valid && cyc < 10) begin
            n_cmp++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
                n_err++; $display("FAIL %s rot_flags: in_ready=%b busy=%b want 0/1", nm, in_ready, busy);
            end
            step();
            cyc++;
        end
        n_cmp++;
        if (cyc !== exp_n) begin n_err++; $display("FAIL %s latency: got %0d want %0d", nm, cyc, exp_n); end
        n_cmp++;
        if (out_data !== exp_d) begin n_err++; $display("FAIL %s data: got %b want %b", nm, out_data, exp_d); end
        n_cmp++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL %s hold_flags: in_ready=%b busy=%b want 0/1", nm, in_ready, busy);
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL %s ready_at_hs: got %b want 0", nm, in_ready); end
        step();
        out_ready = 1'b0;
        exp_cnt = exp_cnt + 2'd1;
        n_cmp++;
        if (done_cnt !== exp_cnt) begin n_err++; $display("FAIL %s done_cnt: got %0d want %0d", nm, done_cnt, exp_cnt); end
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL %s idle_flags: ov=%b busy=%b ir=%b want 0/0/1", nm, out_valid, busy, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 4'd0 || done_cnt !== 2'd0) begin
            n_err++;
            $display("FAIL reset: ir=%b ov=%b busy=%b data=%b cnt=%0d want 0/0/0/0000/0", in_ready, out_valid, busy, out_data, done_cnt);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release: in_ready got %b want 1", in_ready); end
        exp_cnt = 2'd0;
    endtask

    task automatic test_rotations();
        do_op(4'b1001, 2'd1, 1'b1, 4'b0011, 1, "left1");
        do_op(4'b0001, 2'd2, 1'b0, 4'b0100, 2, "right2");
        do_op(4'b1001, 2'd3, 1'b1, 4'b1100, N_AMT3, "left3");
        do_op(4'b0110, 2'd3, 1'b0, 4'b1100, N_AMT3, "right3");
        do_op(4'b1011, 2'd0, 1'b1, 4'b1011, 0, "zero");
    endtask

    task automatic test_backpressure();
        int cyc;
        in_valid = 1'b1; in_data = 4'b0110; in_amt = 2'd1; in_dir = 1'b1;
        step();
        in_data = 4'b1010; in_amt = 2'd0; in_dir = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 10) begin step(); cyc++; end
        n_cmp++;
        if (cyc !== 1 || out_data !== 4'b1100) begin
            n_err++; $display("FAIL bp_first: lat=%0d data=%b want 1/1100", cyc, out_data);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== 4'b1100 || in_ready !== 1'b0) begin
                n_err++; $display("FAIL bp_stall%0d: ov=%b data=%b ir=%b want 1/1100/0", i, out_valid, out_data, in_ready);
            end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_cnt = exp_cnt + 2'd1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || done_cnt !== exp_cnt) begin
            n_err++; $display("FAIL bp_handshake: ov=%b ir=%b cnt=%0d want 0/1/%0d", out_valid, in_ready, done_cnt, exp_cnt);
        end
        step();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 4'b1010) begin
            n_err++; $display("FAIL bp_second: ov=%b data=%b want 1/1010", out_valid, out_data);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_cnt = exp_cnt + 2'd1;
        n_cmp++;
        if (done_cnt !== exp_cnt) begin n_err++; $display("FAIL bp_cnt: got %0d want %0d", done_cnt, exp_cnt); end
    endtask

    task automatic test_reset_mid_op();
        in_valid = 1'b1; in_data = 4'b1001; in_amt = 2'd2; in_dir = 1'b1;
        step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_cmp++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL mid_rot: busy=%b ov=%b want 1/0", busy, out_valid);
        end
        rst = 1'b1;
        step();
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done_cnt !== 2'd0 || in_ready !== 1'b0 || out_data !== 4'd0) begin
            n_err++;
            $display("FAIL mid_reset: ov=%b busy=%b cnt=%0d ir=%b data=%b want 0/0/0/0/0000", out_valid, busy, done_cnt, in_ready, out_data);
        end
        rst = 1'b0;
        exp_cnt = 2'd0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (out_valid !== 1'b0 || done_cnt !== 2'd0) begin
                n_err++; $display("FAIL post_reset%0d: ov=%b cnt=%0d want 0/0", i, out_valid, done_cnt);
            end
        end
        out_ready = 1'b0;
        do_op(4'b1000, 2'd1, 1'b0, 4'b0100, 1, "fresh");
    endtask

    task automatic test_counter_wrap();
        do_op(4'b0011, 2'd2, 1'b1, 4'b1100, 2, "wrap_a");
        do_op(4'b0101, 2'd1, 1'b0, 4'b1010, 1, "wrap_b");
        do_op(4'b1110, 2'd0, 1'b0, 4'b1110, 0, "wrap_c");
        n_cmp++;
        if (done_cnt !== 2'd0) begin n_err++; $display("FAIL wrap: done_cnt got %0d want 0", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_rotations();
        test_backpressure();
        test_reset_mid_op();
        test_counter_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
